// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 access arbiter: FSM states, requester ids,
// default window placement and the window-membership helper.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOCK_JTAG,
        LOCK_SOC
    } arb_state_e;

    typedef enum logic {
        REQ_JTAG,
        REQ_SOC
    } req_id_e;

    localparam logic [31:0] DEF_L2_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_L2_SIZE = 32'h0008_0000;

    // 33-bit compare so a window whose end lands exactly on 2^32 does not wrap to zero.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, size};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/l2_arb_resp.sv
// Per-requester response stage: registers one response per grant and steers read
// data back only for successful in-window reads.
module l2_arb_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic        gnt,
    input  logic        we,
    input  logic        oob,
    input  logic [31:0] mem_rdata,
    output logic        rvalid,
    output logic        err,
    output logic [31:0] rdata
);

    logic valid_q;
    logic err_q;
    logic we_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            valid_q <= gnt;
            err_q   <= gnt & oob;
            we_q    <= gnt & we;
        end
    end

    // A reset arriving while a response is pending swallows that response.
    assign rvalid = valid_q & ~rst;
    assign err    = err_q & ~rst;
    assign rdata  = (rvalid && !we_q && !err_q) ? mem_rdata : 32'h0;

endmodule

// File: rtl/l2_access_arbiter.sv
// Two-master (JTAG bridge, SoC) arbiter onto a single-ported L2 SRAM with
// round-robin tie-break, bus lock, and error responses for out-of-window accesses.
module l2_access_arbiter
    import l2_arb_pkg::*;
#(
    parameter logic [31:0] L2_BASE = DEF_L2_BASE,
    parameter logic [31:0] L2_SIZE = DEF_L2_SIZE,
    parameter int          MEM_AW  = 17
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              jtag_req_i,
    input  logic              jtag_lock_i,
    input  logic              jtag_we_i,
    input  logic [31:0]       jtag_addr_i,
    input  logic [31:0]       jtag_wdata_i,
    input  logic [3:0]        jtag_be_i,
    output logic              jtag_gnt_o,
    output logic              jtag_rvalid_o,
    output logic [31:0]       jtag_rdata_o,
    output logic              jtag_err_o,
    input  logic              soc_req_i,
    input  logic              soc_lock_i,
    input  logic              soc_we_i,
    input  logic [31:0]       soc_addr_i,
    input  logic [31:0]       soc_wdata_i,
    input  logic [3:0]        soc_be_i,
    output logic              soc_gnt_o,
    output logic              soc_rvalid_o,
    output logic [31:0]       soc_rdata_o,
    output logic              soc_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic [31:0]       mem_rdata_i,
    output arb_state_e        dbg_state
);

    arb_state_e  state_q, state_d;
    req_id_e     last_gnt_q, last_gnt_d;
    logic        gnt_jtag, gnt_soc;
    logic        win_we;
    logic [31:0] win_addr, win_wdata, win_off;
    logic [3:0]  win_be;
    logic        win_in, mem_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= REQ_SOC;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        gnt_jtag   = 1'b0;
        gnt_soc    = 1'b0;
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (jtag_req_i && soc_req_i) begin
                        gnt_jtag = (last_gnt_q == REQ_SOC);
                        gnt_soc  = (last_gnt_q == REQ_JTAG);
                    end else begin
                        gnt_jtag = jtag_req_i;
                        gnt_soc  = soc_req_i;
                    end
                end
                LOCK_JTAG: gnt_jtag = jtag_req_i;
                LOCK_SOC:  gnt_soc  = soc_req_i;
                default:   ;
            endcase
        end
        // The lock flag on each granted access decides whether ownership persists.
        if (gnt_jtag) begin
            state_d    = jtag_lock_i ? LOCK_JTAG : IDLE;
            last_gnt_d = REQ_JTAG;
        end
        if (gnt_soc) begin
            state_d    = soc_lock_i ? LOCK_SOC : IDLE;
            last_gnt_d = REQ_SOC;
        end
    end

    assign win_addr  = gnt_soc ? soc_addr_i  : jtag_addr_i;
    assign win_we    = gnt_soc ? soc_we_i    : jtag_we_i;
    assign win_wdata = gnt_soc ? soc_wdata_i : jtag_wdata_i;
    assign win_be    = gnt_soc ? soc_be_i    : jtag_be_i;
    assign win_in    = in_window(win_addr, L2_BASE, L2_SIZE);
    assign win_off   = win_addr - L2_BASE;
    assign mem_hit   = (gnt_jtag | gnt_soc) & win_in;

    assign mem_req_o   = mem_hit;
    assign mem_we_o    = mem_hit & win_we;
    assign mem_addr_o  = mem_hit ? MEM_AW'(win_off >> 2) : '0;
    assign mem_wdata_o = mem_hit ? win_wdata : 32'h0;
    assign mem_be_o    = mem_hit ? win_be : 4'h0;

    assign jtag_gnt_o = gnt_jtag;
    assign soc_gnt_o  = gnt_soc;
    assign dbg_state  = state_q;

    l2_arb_resp u_resp_jtag (
        .clk       (clk_i),
        .rst       (rst_i),
        .gnt       (gnt_jtag),
        .we        (jtag_we_i),
        .oob       (~win_in),
        .mem_rdata (mem_rdata_i),
        .rvalid    (jtag_rvalid_o),
        .err       (jtag_err_o),
        .rdata     (jtag_rdata_o)
    );

    l2_arb_resp u_resp_soc (
        .clk       (clk_i),
        .rst       (rst_i),
        .gnt       (gnt_soc),
        .we        (soc_we_i),
        .oob       (~win_in),
        .mem_rdata (mem_rdata_i),
        .rvalid    (soc_rvalid_o),
        .err       (soc_err_o),
        .rdata     (soc_rdata_o)
    );

endmodule

// File: tb/tb_l2_access_arbiter.sv
// Directed bench for l2_access_arbiter: a small byte-enabled SRAM model feeds
// read data, and every check compares against hand-derived values.
module tb_l2_access_arbiter;
    import l2_arb_pkg::*;

    localparam int MEM_AW = 17;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              jtag_req_i, jtag_lock_i, jtag_we_i;
    logic [31:0]       jtag_addr_i, jtag_wdata_i;
    logic [3:0]        jtag_be_i;
    logic              jtag_gnt_o, jtag_rvalid_o, jtag_err_o;
    logic [31:0]       jtag_rdata_o;
    logic              soc_req_i, soc_lock_i, soc_we_i;
    logic [31:0]       soc_addr_i, soc_wdata_i;
    logic [3:0]        soc_be_i;
    logic              soc_gnt_o, soc_rvalid_o, soc_err_o;
    logic [31:0]       soc_rdata_o;
    logic              mem_req_o, mem_we_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_rdata_i = 32'h0;
    arb_state_e        dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];
    logic [31:0] sram[256];

    always #5 clk = ~clk;

    l2_access_arbiter #(.MEM_AW(MEM_AW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .jtag_req_i(jtag_req_i), .jtag_lock_i(jtag_lock_i), .jtag_we_i(jtag_we_i),
        .jtag_addr_i(jtag_addr_i), .jtag_wdata_i(jtag_wdata_i), .jtag_be_i(jtag_be_i),
        .jtag_gnt_o(jtag_gnt_o), .jtag_rvalid_o(jtag_rvalid_o),
        .jtag_rdata_o(jtag_rdata_o), .jtag_err_o(jtag_err_o),
        .soc_req_i(soc_req_i), .soc_lock_i(soc_lock_i), .soc_we_i(soc_we_i),
        .soc_addr_i(soc_addr_i), .soc_wdata_i(soc_wdata_i), .soc_be_i(soc_be_i),
        .soc_gnt_o(soc_gnt_o), .soc_rvalid_o(soc_rvalid_o),
        .soc_rdata_o(soc_rdata_o), .soc_err_o(soc_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
        .dbg_state(dbg_state)
    );

    // SRAM model: one-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) sram[mem_addr_o[7:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= sram[mem_addr_o[7:0]];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_jtag(input logic req, input logic lock, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        jtag_req_i = req; jtag_lock_i = lock; jtag_we_i = we;
        jtag_addr_i = addr; jtag_wdata_i = wdata; jtag_be_i = be;
    endtask

    task automatic set_soc(input logic req, input logic lock, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        soc_req_i = req; soc_lock_i = lock; soc_we_i = we;
        soc_addr_i = addr; soc_wdata_i = wdata; soc_be_i = be;
    endtask

    task automatic clear_reqs();
        set_jtag(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_soc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic reset_pulse();
        next_cycle();
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
    endtask

    initial begin
        int pulses;
        logic exp_soc;
        logic [32:0] e;
        for (int i = 0; i < 256; i++) sram[i] = 32'h0;
        rst_i = 1'b1;
        set_jtag(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        set_soc(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        next_cycle();
        next_cycle();
        settle();
        check("rst_jtag_gnt", jtag_gnt_o, 1'b0);
        check("rst_soc_gnt", soc_gnt_o, 1'b0);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_state", dbg_state, IDLE);
        check("rst_rvalid", {jtag_rvalid_o, soc_rvalid_o}, 2'b00);

        // JTAG write then read of word 0.
        next_cycle();
        rst_i = 1'b0;
        clear_reqs();
        set_jtag(1'b1, 1'b0, 1'b1, 32'h0, 32'hABBA_ABBA, 4'hF);
        settle();
        check("wr_gnt", {jtag_gnt_o, soc_gnt_o}, 2'b10);
        check("wr_mem", {mem_req_o, mem_we_o, mem_be_o}, {1'b1, 1'b1, 4'hF});
        check("wr_addr", mem_addr_o, 17'h0);
        check("wr_wdata", mem_wdata_o, 32'hABBA_ABBA);
        next_cycle();
        set_jtag(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        settle();
        check("wr_resp", {jtag_rvalid_o, jtag_err_o, jtag_rdata_o}, {1'b1, 1'b0, 32'h0});
        check("wr_soc_quiet", soc_rvalid_o, 1'b0);
        check("rd_mem", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b0, 17'h0});
        next_cycle();
        clear_reqs();
        settle();
        check("rd_resp", {jtag_rvalid_o, jtag_err_o, jtag_rdata_o}, {1'b1, 1'b0, 32'hABBA_ABBA});
        check("idle_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}, 55'h0);
        next_cycle();
        settle();
        check("idle_resp", {jtag_rvalid_o, jtag_rdata_o}, 33'h0);

        // SoC partial write at a non-zero offset, then last word of the window.
        set_soc(1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 4'h3);
        settle();
        check("soc_wr", {soc_gnt_o, jtag_gnt_o, mem_req_o, mem_addr_o, mem_be_o},
              {1'b1, 1'b0, 1'b1, 17'h41, 4'h3});
        next_cycle();
        set_soc(1'b1, 1'b0, 1'b0, 32'h0007_FFFC, 32'h0, 4'hF);
        settle();
        check("top_word", {mem_req_o, mem_addr_o}, {1'b1, 17'h1FFFF});
        check("soc_wr_resp", {soc_rvalid_o, soc_err_o, soc_rdata_o}, {1'b1, 1'b0, 32'h0});

        // First byte past the window: granted, no SRAM strobe, error response.
        next_cycle();
        clear_reqs();
        set_jtag(1'b1, 1'b0, 1'b0, 32'h0008_0000, 32'h0, 4'hF);
        settle();
        check("oob_gnt", {jtag_gnt_o, mem_req_o}, 2'b10);
        next_cycle();
        clear_reqs();
        settle();
        check("oob_resp", {jtag_rvalid_o, jtag_err_o, jtag_rdata_o}, {1'b1, 1'b1, 32'h0});
        check("oob_soc_quiet", soc_rvalid_o, 1'b0);

        // Round-robin from reset with both masters reading continuously.
        reset_pulse();
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                set_jtag(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
                set_soc(1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'hF);
            end else begin
                clear_reqs();
            end
            settle();
            pulses += int'(jtag_rvalid_o) + int'(soc_rvalid_o);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rr_rvalid", {jtag_rvalid_o, soc_rvalid_o}, {~e[32], e[32]});
                check("rr_rdata", e[32] ? soc_rdata_o : jtag_rdata_o, e[31:0]);
            end else begin
                check("rr_first_rvalid", {jtag_rvalid_o, soc_rvalid_o}, 2'b00);
            end
            if (i < 6) begin
                exp_soc = (i % 2 == 1);
                check("rr_gnt", {jtag_gnt_o, soc_gnt_o}, {~exp_soc, exp_soc});
                exp_q.push_back({exp_soc, exp_soc ? 32'h0000_5678 : 32'hABBA_ABBA});
            end
            next_cycle();
        end
        check("rr_pulses", pulses, 6);

        // SoC lock: JTAG goes first so the tie lands on SoC, which then locks.
        set_jtag(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        settle();
        check("pre_lock_gnt", {jtag_gnt_o, soc_gnt_o}, 2'b10);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            set_jtag(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
            set_soc(1'b1, (i < 3), 1'b0, 32'h0, 32'h0, 4'hF);
            settle();
            if (i < 4) begin
                check("lock_gnt", {jtag_gnt_o, soc_gnt_o}, 2'b01);
                check("lock_state", dbg_state, (i == 0) ? IDLE : LOCK_SOC);
            end else begin
                check("unlock_gnt", {jtag_gnt_o, soc_gnt_o}, 2'b10);
                check("unlock_state", dbg_state, IDLE);
            end
        end

        // Reset while JTAG holds the lock with a read in flight.
        next_cycle();
        clear_reqs();
        set_jtag(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        settle();
        check("jlock_gnt", jtag_gnt_o, 1'b1);
        next_cycle();
        set_soc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        settle();
        check("jlock_state", dbg_state, LOCK_JTAG);
        check("jlock_owner_only", {jtag_gnt_o, soc_gnt_o}, 2'b10);
        next_cycle();
        rst_i = 1'b1;
        settle();
        check("rst_drop_rvalid", jtag_rvalid_o, 1'b0);
        check("rst_force_gnt", {jtag_gnt_o, soc_gnt_o, mem_req_o}, 3'b000);
        next_cycle();
        rst_i = 1'b0;
        set_jtag(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF);
        settle();
        check("post_rst_state", dbg_state, IDLE);
        check("post_rst_gnt", {jtag_gnt_o, soc_gnt_o}, 2'b10);
        check("post_rst_rvalid", {jtag_rvalid_o, soc_rvalid_o}, 2'b00);
        next_cycle();
        clear_reqs();
        settle();
        check("post_rst_resp", {jtag_rvalid_o, jtag_rdata_o}, {1'b1, 32'hABBA_ABBA});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
